// File: rtl/mem_access_unit.sv
// Data-memory initiator: latches one MEM-stage load/store, checks it, runs IDLE->RD/WR->DONE.
// Latency: error 1, word store 2, load READ_LAT+1, sub-word store READ_LAT+2; stall_o holds the pipeline.
`timescale 1ns/1ps
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [1:0]     size_q, size_d;
   logic           uns_q, uns_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   logic [2:0]     nbytes;
   logic [32:0]    end_addr;
   logic           req_err;
   logic [7:0]     rd_byte;
   logic [15:0]    rd_half;
   logic [31:0]    load_val;
   logic [31:0]    merged;

   // 33-bit sum so addresses near 2^32 cannot wrap back into range
   assign nbytes   = size_i[1] ? 3'd4 : (size_i[0] ? 3'd2 : 3'd1);
   assign end_addr = {1'b0, addr_i} + {30'd0, nbytes};
   assign req_err  = (size_i == 2'b01 && addr_i[0]) ||
                     (size_i[1] && addr_i[1:0] != 2'b00) ||
                     (end_addr > 33'(MEM_BYTES));

   always_comb begin
      rd_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
      rd_half = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
      if (size_q[1])
         load_val = mem_rdata_i;
      else if (size_q[0])
         load_val = {{16{rd_half[15] & ~uns_q}}, rd_half};
      else
         load_val = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
      merged = mem_rdata_i;
      if (!size_q[1]) begin
         if (size_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               uns_d   = unsigned_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               cnt_d   = '0;
               err_d   = req_err;
               if (req_err) begin
                  rdata_d = '0;
                  state_d = DONE;
               end else if (we_i && size_i[1]) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (cnt_q == CW'(READ_LAT - 1)) begin
               if (we_q) begin
                  wdata_d = merged;
                  state_d = WR;
               end else begin
                  rdata_d = load_val;
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WR: begin
            rdata_d = '0;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Read strobe drops outside RD so every read presents a fresh rising edge
   assign stall_o     = rst_n_i & (((state_q == IDLE) & req_i) | (state_q == RD) | (state_q == WR));
   assign done_o      = (state_q == DONE);
   assign err_o       = (state_q == DONE) & err_q;
   assign rdata_o     = rdata_q;
   assign mem_read_o  = (state_q == RD);
   assign mem_write_o = (state_q == WR);
   assign mem_addr_o  = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_wdata_o = (state_q == WR) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed checks plus randomized loads/stores against a byte-array model.
`timescale 1ns/1ps
module tb_mem_access_unit;
   localparam int MEMB = 32;
   localparam int RL   = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        stall, done, err, mrd, mwr;
   logic [31:0] rdata, maddr, mwdata, mrdata;

   logic [31:0] mem_w [8];
   logic        mem_clr;
   logic [7:0]  mdl [MEMB];
   int          errors = 0;
   int          checks = 0;

   mem_access_unit #(.MEM_BYTES(MEMB), .READ_LAT(RL)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
      .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
      .done_o(done), .err_o(err), .rdata_o(rdata), .mem_addr_o(maddr),
      .mem_wdata_o(mwdata), .mem_read_o(mrd), .mem_write_o(mwr),
      .mem_rdata_i(mrdata)
   );

   always #5 clk = ~clk;

   assign mrdata = mrd ? mem_w[maddr[4:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 8; i++) mem_w[i] <= 32'h0;
      end else if (mwr) begin
         mem_w[maddr[4:2]] <= mwdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic is_err(input logic [1:0] s, input logic [31:0] a);
      int nb = nbytes_of(s);
      if (nb == 2 && a % 2 != 0) return 1'b1;
      if (nb == 4 && a % 4 != 0) return 1'b1;
      return (longint'(a) + nb > MEMB);
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] s, input logic u, input logic [31:0] a);
      int nb = nbytes_of(s);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[a + i];
      if (!u && nb < 4 && v[8*nb-1]) begin
         for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [31:0] mdl_word(input logic [31:0] a);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mdl[(a & ~32'd3) + i];
      return v;
   endfunction

   // Starts and ends at a falling edge with the DUT idle
   task automatic do_op(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_rd, output logic got_err);
      logic        e_err = is_err(s, a);
      int          nb = nbytes_of(s);
      int          e_n, e_reads, e_writes, n, reads, writes, bad_addr, bad_stall, bad_wd, both;
      logic [31:0] e_rd = 32'h0;
      logic [31:0] e_wword = 32'h0;
      if (!e_err && !w) e_rd = mdl_load(s, u, a);
      if (!e_err && w) begin
         for (int i = 0; i < nb; i++) mdl[a + i] = d[8*i +: 8];
         e_wword = mdl_word(a);
      end
      e_n      = e_err ? 1 : (w && nb == 4) ? 2 : w ? RL + 2 : RL + 1;
      e_reads  = (e_err || (w && nb == 4)) ? 0 : RL;
      e_writes = (!e_err && w) ? 1 : 0;
      req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
      #1 check("stall_accept", {31'b0, stall}, 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); we = ~w; uns = ~u;
      n = 0; reads = 0; writes = 0; bad_addr = 0; bad_stall = 0; bad_wd = 0; both = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mrd) reads++;
         if (mwr) writes++;
         if (mrd && mwr) both++;
         if ((mrd || mwr) && maddr !== {a[31:2], 2'b00}) bad_addr++;
         if (mwr && mwdata !== e_wword) bad_wd++;
         if (done) begin
            n = c;
            break;
         end
         if (stall !== 1'b1) bad_stall++;
      end
      got_rd = rdata; got_err = err;
      check("latency", n, e_n);
      check("err", {31'b0, err}, {31'b0, e_err});
      check("rdata", rdata, e_rd);
      check("stall_done", {31'b0, stall}, 32'd0);
      check("reads", reads, e_reads);
      check("writes", writes, e_writes);
      check("rd_wr_overlap", both, 0);
      check("mem_addr", bad_addr, 0);
      check("mem_wdata", bad_wd, 0);
      check("stall_busy", bad_stall, 0);
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 32'd0);
   endtask

   logic [31:0] r;
   logic        e;
   logic [5:0]  stall_pat, rd_pat;

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = 0; wdata = 0;
      mem_clr = 1'b1;
      for (int i = 0; i < MEMB; i++) mdl[i] = 8'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_clr = 1'b0;
      check("reset_ctl", {27'b0, stall, done, err, mrd, mwr}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_maddr", maddr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(1, 2'd2, 0, 8, 32'hDEADBEEF, r, e);
      do_op(0, 2'd2, 0, 8, 0, r, e);  check("lw8", r, 32'hDEADBEEF);
      do_op(0, 2'd0, 0, 9, 0, r, e);  check("lb9", r, 32'hFFFFFFBE);
      do_op(0, 2'd0, 1, 9, 0, r, e);  check("lbu9", r, 32'h000000BE);
      do_op(0, 2'd1, 0, 10, 0, r, e); check("lh10", r, 32'hFFFFDEAD);
      do_op(0, 2'd1, 1, 10, 0, r, e); check("lhu10", r, 32'h0000DEAD);
      do_op(1, 2'd0, 0, 9, 32'h12, r, e);
      do_op(0, 2'd2, 0, 8, 0, r, e);  check("sb9_word", r, 32'hDEAD12EF);
      do_op(1, 2'd1, 0, 10, 32'hCAFE, r, e);
      do_op(0, 2'd2, 0, 8, 0, r, e);  check("sh10_word", r, 32'hCAFE12EF);
      do_op(1, 2'd1, 0, 7, 32'h1, r, e);  check("sh7_err", {31'b0, e}, 32'd1);
      do_op(0, 2'd2, 0, 5, 0, r, e);      check("lw5_err", {31'b0, e}, 32'd1);
      do_op(0, 2'd2, 0, 30, 0, r, e);     check("lw30_err", {31'b0, e}, 32'd1);
      do_op(0, 2'd3, 0, 32'hFFFFFFFC, 0, r, e); check("lw_wrap_err", {31'b0, e}, 32'd1);

      // Reset while the sb 9 read-modify-write is in its read phase
      req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 9; wdata = 32'h55;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("rst_pre_rd", {31'b0, mrd}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ctl", {27'b0, stall, done, err, mrd, mwr}, 32'd0);
      check("rst_mid_rdata", rdata, 32'd0);
      check("rst_mid_bus", maddr | mwdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int wr_seen = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mwr) wr_seen++;
         end
         check("rst_no_write", wr_seen, 0);
      end
      do_op(0, 2'd2, 0, 8, 0, r, e); check("post_rst_lw8", r, 32'hCAFE12EF);

      // Back-to-back loads with req held high
      do_op(1, 2'd2, 0, 12, 32'h13572468, r, e);
      stall_pat = 6'b011011;
      rd_pat    = 6'b010010;
      req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 8;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check($sformatf("b2b_stall%0d", k), {31'b0, stall}, {31'b0, stall_pat[k]});
         check($sformatf("b2b_rd%0d", k), {31'b0, mrd}, {31'b0, rd_pat[k]});
         if (k == 1) addr = 12;
         if (k == 4) addr = 0;
         if (k == 2) check("b2b_first", rdata, mdl_load(2'd2, 0, 8));
         if (k == 5) check("b2b_second", rdata, mdl_load(2'd2, 0, 12));
      end
      req = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 200; t++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 35));
         do_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, r, e);
      end
      for (int i = 0; i < 8; i++) check($sformatf("mem_final%0d", i), mem_w[i], mdl_word(32'(4*i)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
